alu_result_collector: RTL and testbench
=======================================

Name: alu_result_collector

Overview:
- Consumer end of the ALU unit output interface. Each execution unit (arithmetic, logic, compare, shift) produces a registered result qualified by a one-cycle flag.
- This block captures each flag-qualified result, tags it with its source unit, and buffers it in a small FIFO.
- It presents buffered results downstream over a valid/ready handshake, with sticky error reporting.
- Sits between the ALU execution units and the writeback/output stage.

Parameters:
- DATA_WIDTH, 32, width of every unit result input and of Res_Data. Integration sign-extends Arith_OUT and zero-extends the narrower outputs.
- FIFO_DEPTH, 4, number of result entries. Power of two, minimum 2.
- CNT_WIDTH, 3, occupancy counter width. Must satisfy 2^CNT_WIDTH > FIFO_DEPTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
- Arith_OUT  input  DATA_WIDTH  arithmetic unit result.
- Arith_Flag  input  1  Arith_OUT valid this cycle.
- Logic_OUT  input  DATA_WIDTH  logic unit result.
- Logic_Flag  input  1  Logic_OUT valid this cycle.
- CMP_OUT  input  DATA_WIDTH  compare unit result.
- CMP_Flag  input  1  CMP_OUT valid this cycle.
- Shift_OUT  input  DATA_WIDTH  shift unit result.
- Shift_Flag  input  1  Shift_OUT valid this cycle.
- Res_Ready  input  1  downstream accepts the head entry.
- Err_Clr  input  1  clears the sticky error bits.
- Res_Valid  output  1  head entry present.
- Res_Data  output  DATA_WIDTH  head entry result.
- Res_Src  output  2  head entry source: 00 arith, 01 logic, 10 cmp, 11 shift.
- Fifo_Count  output  CNT_WIDTH  current occupancy.
- Full  output  1  Fifo_Count == FIFO_DEPTH.
- Overflow_Err  output  1  sticky; a result was dropped.
- Collision_Err  output  1  sticky; more than one flag was high in the same cycle.

Behaviour:
- Reset (RST low at a rising edge):
  - Pointers, Fifo_Count, Res_Valid, Full, Overflow_Err and Collision_Err all go to 0.
  - Res_Data and Res_Src go to 0.
  - Reset overrides every other input, including mid-transfer; buffered contents are discarded.
- Push request: any flag high in a cycle. Selection is by fixed priority Arith > Logic > CMP > Shift.
  - Exactly one entry is pushed per cycle.
  - If two or more flags are high, Collision_Err sets and the lower-priority results are discarded (not counted as overflow).
- Pop: Res_Valid && Res_Ready at a rising edge; the head pointer advances.
- Push acceptance: a push is accepted when not Full, or when Full and a pop occurs in the same cycle.
  - Push while Full without a pop drops the result, sets Overflow_Err, and leaves the contents unchanged.
- Simultaneous push and pop: Fifo_Count is unchanged, both pointers advance, and ordering is preserved.
- Pop when empty cannot occur, because Res_Valid is low; Res_Ready is ignored when empty.
- Pointers: wrap modulo FIFO_DEPTH.
- Fifo_Count: increments on push-only and decrements on pop-only.
- Registered outputs:
  - Full, Res_Valid (Fifo_Count != 0), Res_Data and Res_Src are registered.
  - Res_Data/Res_Src always reflect the head entry.
  - When the FIFO is empty, Res_Data/Res_Src hold their last value and carry no meaning.
- Latency: a flag sampled at edge N gives Res_Valid high after edge N (visible in cycle N+1) when the FIFO was empty. A pass-through bypass is not provided.
- Res_Valid stays high and Res_Data/Res_Src stay stable until the entry is popped; there is no retraction.
- Sticky errors:
  - Overflow_Err and Collision_Err clear on Err_Clr high.
  - If a set condition and Err_Clr occur in the same cycle, set wins.
- Data handling: no arithmetic on data; results pass bit-exact.

Optional Feature:
- Macro ALU_RESULT_PARITY_EN.
- When defined:
  - Each entry stores an even-parity bit computed over {Res_Src, data} at push time.
  - Output port Res_Parity (1 bit, reset 0) is added and tracks the head entry with Res_Data.
- When undefined: the port and its storage are absent, and all other behaviour is identical.

Test Plan:
- Reset then single Shift_Flag with Shift_OUT=0x0000_1FFFE -> one cycle later Res_Valid=1, Res_Data=0x0001FFFE, Res_Src=11, Fifo_Count=1.
- Res_Ready=0; push Arith 1, Logic 2, CMP 3, Shift 4 on consecutive cycles, then a fifth push (Arith 5):
  - Full=1 after the fourth push; Overflow_Err=1 after the fifth; entry 5 is absent.
  - Raising Res_Ready drains 1, 2, 3, 4 in order with Src 00, 01, 10, 11.
- Full FIFO, Res_Ready=1 and Logic_Flag with 0xAA in the same cycle -> no overflow, Fifo_Count stays 4, and 0xAA emerges last.
- Arith_Flag=1 (0x10) and Shift_Flag=1 (0x20) together -> only 0x10 is stored (Src 00); Collision_Err=1.
  - Err_Clr pulse clears it; Err_Clr together with a new collision leaves it set.
- Three entries buffered, RST low for one edge -> Res_Valid=0, Fifo_Count=0, errors 0.
  - The next push appears with Fifo_Count=1.
- With ALU_RESULT_PARITY_EN: push CMP 0x0000_0001 (Src 10) -> Res_Parity=0; push CMP 0x0000_0003 -> Res_Parity=1.

Source files
------------

// File: rtl/alu_result_collector.sv
// ---------------------------------------------------------------------------
// alu_result_collector
// Captures flag-qualified results from the four ALU execution units, tags
// each one with its source unit and buffers it in a small FIFO. The buffered
// results are then presented downstream over a valid/ready handshake. Errors
// (dropped result, simultaneous flags) are sticky.
//
// Optional feature: define ALU_RESULT_PARITY_EN to store an even-parity bit
// over {src, data} with each entry and expose it on Res_Parity.
//
// Ports:
//   CLK            clock, rising edge
//   RST            synchronous active-low reset
//   Arith_OUT/Flag arithmetic unit result + valid strobe (highest priority)
//   Logic_OUT/Flag logic unit result + valid strobe
//   CMP_OUT/Flag   compare unit result + valid strobe
//   Shift_OUT/Flag shift unit result + valid strobe (lowest priority)
//   Res_Ready      downstream accepts the head entry
//   Err_Clr        clears sticky error bits (a same-cycle set wins)
//   Res_Valid      head entry present
//   Res_Data       head entry result
//   Res_Src        head entry source: 00 arith, 01 logic, 10 cmp, 11 shift
//   Fifo_Count     current occupancy
//   Full           Fifo_Count == FIFO_DEPTH
//   Overflow_Err   sticky: a result was dropped because the FIFO was full
//   Collision_Err  sticky: more than one flag high in the same cycle
//   Res_Parity     (ALU_RESULT_PARITY_EN only) even parity of head entry
// ---------------------------------------------------------------------------
module alu_result_collector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] Arith_OUT,
  input  logic                  Arith_Flag,
  input  logic [DATA_WIDTH-1:0] Logic_OUT,
  input  logic                  Logic_Flag,
  input  logic [DATA_WIDTH-1:0] CMP_OUT,
  input  logic                  CMP_Flag,
  input  logic [DATA_WIDTH-1:0] Shift_OUT,
  input  logic                  Shift_Flag,
  input  logic                  Res_Ready,
  input  logic                  Err_Clr,
  output logic                  Res_Valid,
  output logic [DATA_WIDTH-1:0] Res_Data,
  output logic [1:0]            Res_Src,
  output logic [CNT_WIDTH-1:0]  Fifo_Count,
  output logic                  Full,
  output logic                  Overflow_Err,
  output logic                  Collision_Err
`ifdef ALU_RESULT_PARITY_EN
  ,
  output logic                  Res_Parity
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [1:0]            mem_src  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;

  logic                  push_req;
  logic                  push_acc;
  logic                  pop;
  logic                  collision;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [1:0]            sel_src;
  logic [DATA_WIDTH-1:0] head_data;
  logic [1:0]            head_src;

`ifdef ALU_RESULT_PARITY_EN
  logic                  mem_par [FIFO_DEPTH];
  logic                  sel_par;
  logic                  head_par;
`endif

  // Fixed-priority source selection: Arith > Logic > CMP > Shift.
  always_comb begin
    sel_data  = Shift_OUT;
    sel_src   = 2'b11;
    push_req  = Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag;
    collision = (Arith_Flag & Logic_Flag) | (Arith_Flag & CMP_Flag) |
                (Arith_Flag & Shift_Flag) | (Logic_Flag & CMP_Flag) |
                (Logic_Flag & Shift_Flag) | (CMP_Flag & Shift_Flag);
    if (Arith_Flag) begin
      sel_data = Arith_OUT;
      sel_src  = 2'b00;
    end else if (Logic_Flag) begin
      sel_data = Logic_OUT;
      sel_src  = 2'b01;
    end else if (CMP_Flag) begin
      sel_data = CMP_OUT;
      sel_src  = 2'b10;
    end
  end

`ifdef ALU_RESULT_PARITY_EN
  assign sel_par = ^{sel_src, sel_data};
`endif

  // Handshake, occupancy and next-head lookahead so the outputs stay registered
  // yet reflect a push into an empty FIFO one cycle after the flag.
  always_comb begin
    pop        = Res_Valid & Res_Ready;
    push_acc   = push_req & (~Full | pop);
    overflow   = push_req & Full & ~pop;
    rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    cnt_nxt    = Fifo_Count;
    if (push_acc && !pop) begin
      cnt_nxt = Fifo_Count + CNT_WIDTH'(1);
    end else if (pop && !push_acc) begin
      cnt_nxt = Fifo_Count - CNT_WIDTH'(1);
    end
    // The entry being written becomes the head when it lands on the next read slot.
    if (push_acc && (rd_ptr_nxt == wr_ptr)) begin
      head_data = sel_data;
      head_src  = sel_src;
    end else begin
      head_data = mem_data[rd_ptr_nxt];
      head_src  = mem_src[rd_ptr_nxt];
    end
`ifdef ALU_RESULT_PARITY_EN
    head_par = (push_acc && (rd_ptr_nxt == wr_ptr)) ? sel_par : mem_par[rd_ptr_nxt];
`endif
  end

  // Entry storage; contents need no reset since the pointers define validity.
  always_ff @(posedge CLK) begin
    if (RST && push_acc) begin
      mem_data[wr_ptr] <= sel_data;
      mem_src[wr_ptr]  <= sel_src;
`ifdef ALU_RESULT_PARITY_EN
      mem_par[wr_ptr]  <= sel_par;
`endif
    end
  end

  // Pointers, occupancy, registered head outputs and sticky errors.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      Fifo_Count    <= '0;
      Res_Valid     <= 1'b0;
      Full          <= 1'b0;
      Res_Data      <= '0;
      Res_Src       <= '0;
      Overflow_Err  <= 1'b0;
      Collision_Err <= 1'b0;
`ifdef ALU_RESULT_PARITY_EN
      Res_Parity    <= 1'b0;
`endif
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr     <= rd_ptr_nxt;
      Fifo_Count <= cnt_nxt;
      Res_Valid  <= (cnt_nxt != '0);
      Full       <= (cnt_nxt == CNT_WIDTH'(FIFO_DEPTH));
      // Head outputs hold their last value once the FIFO drains.
      if (cnt_nxt != '0) begin
        Res_Data   <= head_data;
        Res_Src    <= head_src;
`ifdef ALU_RESULT_PARITY_EN
        Res_Parity <= head_par;
`endif
      end
      Overflow_Err  <= overflow  | (Overflow_Err  & ~Err_Clr);
      Collision_Err <= collision | (Collision_Err & ~Err_Clr);
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
module tb_alu_result_collector;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
  logic          Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic          Res_Ready, Err_Clr;
  logic          Res_Valid;
  logic [DW-1:0] Res_Data;
  logic [1:0]    Res_Src;
  logic [CW-1:0] Fifo_Count;
  logic          Full, Overflow_Err, Collision_Err;
`ifdef ALU_RESULT_PARITY_EN
  logic          Res_Parity;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  alu_result_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST),
    .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag),
    .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
    .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
    .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
    .Res_Ready(Res_Ready), .Err_Clr(Err_Clr),
    .Res_Valid(Res_Valid), .Res_Data(Res_Data), .Res_Src(Res_Src),
    .Fifo_Count(Fifo_Count), .Full(Full),
    .Overflow_Err(Overflow_Err), .Collision_Err(Collision_Err)
`ifdef ALU_RESULT_PARITY_EN
    , .Res_Parity(Res_Parity)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {src, data} with sticky error flags.
  logic [DW+1:0] q[$];
  logic          m_ov, m_col, live;
  logic [DW+1:0] m_head;

  initial live = 1'b0;

  always @(posedge CLK) begin
    if (!RST) begin
      q.delete();
      m_ov   = 1'b0;
      m_col  = 1'b0;
      m_head = '0;
      live   = 1'b1;
    end else if (live) begin
      int nflags;
      logic pop, req, ovf;
      logic [DW+1:0] entry;
      nflags = int'(Arith_Flag) + int'(Logic_Flag) + int'(CMP_Flag) + int'(Shift_Flag);
      req    = nflags > 0;
      pop    = (q.size() > 0) && Res_Ready;
      if (Arith_Flag)      entry = {2'd0, Arith_OUT};
      else if (Logic_Flag) entry = {2'd1, Logic_OUT};
      else if (CMP_Flag)   entry = {2'd2, CMP_OUT};
      else                 entry = {2'd3, Shift_OUT};
      ovf = req && (q.size() == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (req && !ovf) q.push_back(entry);
      m_ov  = ovf ? 1'b1 : (Err_Clr ? 1'b0 : m_ov);
      m_col = (nflags > 1) ? 1'b1 : (Err_Clr ? 1'b0 : m_col);
      if (q.size() > 0) m_head = q[0];
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge CLK) begin
    if (live) begin
      check("valid", DW'(Res_Valid), DW'(q.size() != 0));
      check("count", DW'(Fifo_Count), DW'(q.size()));
      check("full", DW'(Full), DW'(q.size() == DEPTH));
      check("ovf_err", DW'(Overflow_Err), DW'(m_ov));
      check("col_err", DW'(Collision_Err), DW'(m_col));
      check("data", Res_Data, m_head[DW-1:0]);
      check("src", DW'(Res_Src), DW'(m_head[DW+1:DW]));
`ifdef ALU_RESULT_PARITY_EN
      check("parity", DW'(Res_Parity), DW'(^m_head));
`endif
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_flags();
    Arith_Flag = 0; Logic_Flag = 0; CMP_Flag = 0; Shift_Flag = 0;
  endtask

  task automatic push(input int unsigned unit, input logic [DW-1:0] val);
    clr_flags();
    case (unit)
      0: begin Arith_Flag = 1; Arith_OUT = val; end
      1: begin Logic_Flag = 1; Logic_OUT = val; end
      2: begin CMP_Flag   = 1; CMP_OUT   = val; end
      default: begin Shift_Flag = 1; Shift_OUT = val; end
    endcase
    cyc();
    clr_flags();
  endtask

  initial begin
    RST = 0; Res_Ready = 0; Err_Clr = 0; clr_flags();
    Arith_OUT = '0; Logic_OUT = '0; CMP_OUT = '0; Shift_OUT = '0;
    cyc(); cyc();
    check("rst_valid", DW'(Res_Valid), 0);
    check("rst_data", Res_Data, 0);
    RST = 1;
    cyc();

    // Single shift result, one-cycle latency
    push(3, 32'h0001FFFE);
    check("t1_valid", DW'(Res_Valid), 1);
    check("t1_data", Res_Data, 32'h0001FFFE);
    check("t1_src", DW'(Res_Src), 3);
    check("t1_count", DW'(Fifo_Count), 1);
    Res_Ready = 1; cyc(); Res_Ready = 0;

    // Fill, overflow, ordered drain
    for (int i = 0; i < 4; i++) push(i, DW'(i + 1));
    check("t2_full", DW'(Full), 1);
    push(0, 32'd5);
    check("t2_ovf", DW'(Overflow_Err), 1);
    check("t2_count", DW'(Fifo_Count), 4);
    Res_Ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_data", Res_Data, DW'(i + 1));
      check("t2_drain_src", DW'(Res_Src), DW'(i));
      cyc();
    end
    Res_Ready = 0;
    check("t2_empty", DW'(Res_Valid), 0);
    Err_Clr = 1; cyc(); Err_Clr = 0;
    check("t2_ovf_clr", DW'(Overflow_Err), 0);

    // Push + pop while full
    for (int i = 0; i < 4; i++) push(0, DW'(32'h100 + i));
    Res_Ready = 1; Logic_Flag = 1; Logic_OUT = 32'hAA;
    cyc();
    clr_flags(); Res_Ready = 0;
    check("t3_count", DW'(Fifo_Count), 4);
    check("t3_ovf", DW'(Overflow_Err), 0);
    check("t3_head", Res_Data, 32'h101);
    Res_Ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        check("t3_last_data", Res_Data, 32'hAA);
        check("t3_last_src", DW'(Res_Src), 1);
      end
      cyc();
    end
    Res_Ready = 0;

    // Collision and sticky clear
    Arith_Flag = 1; Arith_OUT = 32'h10; Shift_Flag = 1; Shift_OUT = 32'h20;
    cyc(); clr_flags();
    check("t4_col", DW'(Collision_Err), 1);
    check("t4_data", Res_Data, 32'h10);
    check("t4_src", DW'(Res_Src), 0);
    check("t4_count", DW'(Fifo_Count), 1);
    Err_Clr = 1; cyc(); Err_Clr = 0;
    check("t4_col_clr", DW'(Collision_Err), 0);
    Err_Clr = 1; Logic_Flag = 1; Logic_OUT = 32'h1; CMP_Flag = 1; CMP_OUT = 32'h2;
    cyc(); clr_flags(); Err_Clr = 0;
    check("t4_col_set_wins", DW'(Collision_Err), 1);
    check("t4_count2", DW'(Fifo_Count), 2);

    // Reset with entries buffered
    push(2, 32'h3);
    check("t5_count3", DW'(Fifo_Count), 3);
    RST = 0; cyc(); RST = 1;
    check("t5_valid", DW'(Res_Valid), 0);
    check("t5_count", DW'(Fifo_Count), 0);
    check("t5_col", DW'(Collision_Err), 0);
    push(0, 32'h7);
    check("t5_count_after", DW'(Fifo_Count), 1);
    check("t5_data_after", Res_Data, 32'h7);
    Res_Ready = 1; cyc(); Res_Ready = 0;

`ifdef ALU_RESULT_PARITY_EN
    push(2, 32'h1);
    check("t6_par0", DW'(Res_Parity), 0);
    Res_Ready = 1; cyc(); Res_Ready = 0;
    push(2, 32'h3);
    check("t6_par1", DW'(Res_Parity), 1);
    Res_Ready = 1; cyc(); Res_Ready = 0;
`endif

    // Mixed traffic, checked by the model
    for (int i = 0; i < 400; i++) begin
      Arith_Flag = ($urandom_range(0, 5) == 0);
      Logic_Flag = ($urandom_range(0, 5) == 0);
      CMP_Flag   = ($urandom_range(0, 5) == 0);
      Shift_Flag = ($urandom_range(0, 5) == 0);
      Arith_OUT  = $urandom; Logic_OUT = $urandom;
      CMP_OUT    = $urandom; Shift_OUT = $urandom;
      Res_Ready  = ($urandom_range(0, 2) != 0);
      Err_Clr    = ($urandom_range(0, 15) == 0);
      RST        = ($urandom_range(0, 99) != 0);
      cyc();
    end
    clr_flags(); Res_Ready = 0; Err_Clr = 0; RST = 1;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
